// File: rtl/l1_mem_responder.sv
// Line-granular memory responder below the L2: one outstanding request, fixed response latency.
// Optional request counters are compiled in with `define L1_MEM_RESPONDER_STATS_EN.
module l1_mem_responder #(
    parameter int         ADDR_W   = 32,
    parameter int         LG_LINES = 10,
    parameter int         LATENCY  = 4,
    parameter logic [3:0] OP_LOAD  = 4'd4,
    parameter logic [3:0] OP_STORE = 4'd7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req_valid,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [511:0]      mem_req_store_data,
    input  logic [3:0]        mem_req_opcode,
    output logic              mem_rsp_valid,
    output logic [511:0]      mem_rsp_load_data,
    output logic              busy,
    output logic              err
`ifdef L1_MEM_RESPONDER_STATS_EN
    ,
    output logic [63:0]       load_count,
    output logic [63:0]       store_count,
    output logic [31:0]       err_count
`endif
);

    localparam int         LINES    = 1 << LG_LINES;
    localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    logic [511:0] mem [0:LINES-1];

    state_t        state_q, state_d;
    logic [7:0]    lat_cnt_q, lat_cnt_d;
    logic [511:0]  line_q, line_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [511:0]  rsp_data_q, rsp_data_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic [LG_LINES-1:0] idx_s;
    logic                addr_oor_s;
    logic                op_load_s;
    logic                op_store_s;
    logic                req_bad_s;
    logic                accept_s;
    logic                wr_en_s;
    logic [511:0]        rd_line_s;

    // Any address bit above the backing-store window makes the request out of range.
    assign idx_s      = mem_req_addr[LG_LINES+5:6];
    assign addr_oor_s = |(mem_req_addr >> (LG_LINES + 6));
    assign op_load_s  = (mem_req_opcode == OP_LOAD);
    assign op_store_s = (mem_req_opcode == OP_STORE);
    assign req_bad_s  = addr_oor_s || !(op_load_s || op_store_s);
    assign accept_s   = (state_q == S_IDLE) && mem_req_valid;
    assign wr_en_s    = accept_s && op_store_s && !addr_oor_s;
    assign rd_line_s  = (op_load_s && !addr_oor_s) ? mem[idx_s] : '0;

    // Backing store: written on the accept edge of a good store, never reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[idx_s] <= mem_req_store_data;
        end
    end

    // Next-state and next-output logic for the request/response sequencer.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        line_d      = line_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        busy_d      = busy_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    line_d    = rd_line_s;
                    lat_cnt_d = LAT_INIT;
                    busy_d    = 1'b1;
                    if (req_bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    // With unit latency the response goes out straight from the array read.
                    if (LATENCY == 1) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rd_line_s;
                    end else begin
                        state_d = S_BUSY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                lat_cnt_d = lat_cnt_q - 8'd1;
                if (lat_cnt_q <= 8'd1) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = line_q;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_RESP: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lat_cnt_q   <= 8'd0;
            line_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            line_q      <= line_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign mem_rsp_valid     = rsp_valid_q;
    assign mem_rsp_load_data = rsp_data_q;
    assign busy              = busy_q;
    assign err               = err_q;

`ifdef L1_MEM_RESPONDER_STATS_EN
    logic [63:0] load_count_q, load_count_d;
    logic [63:0] store_count_q, store_count_d;
    logic [31:0] err_count_q, err_count_d;

    // Saturating request counters, bumped on the accept edge by opcode and by error.
    always_comb begin
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        err_count_d   = err_count_q;
        if (accept_s && op_load_s && (load_count_q != {64{1'b1}})) begin
            load_count_d = load_count_q + 64'd1;
        end else begin
            load_count_d = load_count_q;
        end
        if (accept_s && op_store_s && (store_count_q != {64{1'b1}})) begin
            store_count_d = store_count_q + 64'd1;
        end else begin
            store_count_d = store_count_q;
        end
        if (accept_s && req_bad_s && (err_count_q != {32{1'b1}})) begin
            err_count_d = err_count_q + 32'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_count_q  <= 64'd0;
            store_count_q <= 64'd0;
            err_count_q   <= 32'd0;
        end else begin
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign load_count  = load_count_q;
    assign store_count = store_count_q;
    assign err_count   = err_count_q;
`endif

endmodule
